jag_controller_scanner: RTL and testbench



---
 rtl/jag_controller_scanner_if.sv | 35 +++
 rtl/jag_controller_scanner.sv | 155 +++++++++++++++
 tb/tb_jag_controller_scanner.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jag_controller_scanner_if.sv
// jag_controller_scanner_if
// Bundles the joypad-port pins and the software-facing button outputs of the scanner.
//   en        scan enable (master -> scanner)
//   row_n     row returns [6:1], active-low, async to clk (pad -> scanner)
//   col_n     column selects [3:0], active-low (scanner -> pad)
//   buttons   21-bit active-high button state (scanner -> software)
//   scan_done one-cycle pulse when buttons is updated
//   changed   one-cycle pulse with scan_done when buttons differs from its previous value
// Modports: master = pad/software side, slave = scanner.
interface jag_controller_scanner_if;
   logic        en;
   logic [6:1]  row_n;
   logic [3:0]  col_n;
   logic [20:0] buttons;
   logic        scan_done;
   logic        changed;

   modport master (
      output en,
      output row_n,
      input  col_n,
      input  buttons,
      input  scan_done,
      input  changed
   );

   modport slave (
      input  en,
      input  row_n,
      output col_n,
      output buttons,
      output scan_done,
      output changed
   );
endinterface

// File: rtl/jag_controller_scanner.sv
// jag_controller_scanner
// Walks the four active-low column selects of a Jaguar joypad, samples the six row
// returns through a 2-flop synchronizer on the last cycle of each column, and publishes
// the 21 buttons as an active-high vector once per complete 4-column scan.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      jag_controller_scanner_if.slave (en, row_n, col_n, buttons, scan_done, changed)
// Parameter:
//   SETTLE   cycles each column is held low before sampling (3 or more)
module jag_controller_scanner #(
   parameter int unsigned SETTLE = 16
) (
   input logic                     clk,
   input logic                     reset_n,
   jag_controller_scanner_if.slave bus
);

   localparam int unsigned    CntW    = (SETTLE > 2) ? $clog2(SETTLE) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StGap
   } state_e;

   state_e          r_state, w_state_nxt;
   logic [1:0]      r_col, w_col_nxt;        // 0..3 selects column 1..4
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [6:1]      r_rs1, r_rs2;
   logic [14:0]     r_shadow, w_shadow_nxt;  // [4:0] col 1, [9:5] col 2, [14:10] col 3
   logic [20:0]     r_buttons, w_buttons_nxt;
   logic            r_scan_done, w_scan_done_nxt;
   logic            r_changed, w_changed_nxt;
   logic [3:0]      r_col_n, w_col_n_nxt;
   logic [6:1]      w_hit;
   logic [20:0]     w_commit;

   assign w_hit = ~r_rs2;

   // Shadow slot bits are rs[2..6] of that column; col 4 comes straight from the live sample.
   assign w_commit = {
      r_shadow[4],   // 20 hash
      r_shadow[14],  // 19 star
      r_shadow[3],   // 18 digit 9
      r_shadow[8],   // 17 digit 8
      r_shadow[13],  // 16 digit 7
      r_shadow[2],   // 15 digit 6
      r_shadow[7],   // 14 digit 5
      r_shadow[12],  // 13 digit 4
      r_shadow[1],   // 12 digit 3
      r_shadow[6],   // 11 digit 2
      r_shadow[11],  // 10 digit 1
      r_shadow[9],   //  9 digit 0
      w_hit[1],      //  8 pause
      r_shadow[0],   //  7 option
      r_shadow[5],   //  6 c
      r_shadow[10],  //  5 b
      w_hit[2],      //  4 a
      w_hit[6],      //  3 up
      w_hit[5],      //  2 down
      w_hit[4],      //  1 left
      w_hit[3]       //  0 right
   };

   always_comb begin
      w_state_nxt     = r_state;
      w_col_nxt       = r_col;
      w_cnt_nxt       = r_cnt;
      w_shadow_nxt    = r_shadow;
      w_buttons_nxt   = r_buttons;
      w_scan_done_nxt = 1'b0;
      w_changed_nxt   = 1'b0;

      case (r_state)
         StIdle: begin
            if (bus.en) begin
               w_state_nxt = StDrive;
               w_col_nxt   = 2'd0;
               w_cnt_nxt   = CntLoad;
            end
         end
         StDrive: begin
            if (r_cnt == '0) begin
               w_state_nxt = StGap;
               case (r_col)
                  2'd0:    w_shadow_nxt[4:0]   = w_hit[6:2];
                  2'd1:    w_shadow_nxt[9:5]   = w_hit[6:2];
                  2'd2:    w_shadow_nxt[14:10] = w_hit[6:2];
                  default: begin
                     w_buttons_nxt   = w_commit;
                     w_scan_done_nxt = 1'b1;
                     w_changed_nxt   = (w_commit != r_buttons);
                  end
               endcase
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StGap: begin
            if (r_col != 2'd3) begin
               w_state_nxt = StDrive;
               w_col_nxt   = r_col + 2'd1;
               w_cnt_nxt   = CntLoad;
            end else if (bus.en) begin
               w_state_nxt = StDrive;
               w_col_nxt   = 2'd0;
               w_cnt_nxt   = CntLoad;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      // col_n is registered from the next state so the pins never glitch.
      w_col_n_nxt = 4'b1111;
      if (w_state_nxt == StDrive) begin
         w_col_n_nxt = ~(4'b0001 << w_col_nxt);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_col       <= 2'd0;
         r_cnt       <= '0;
         r_rs1       <= 6'b111111;
         r_rs2       <= 6'b111111;
         r_shadow    <= '0;
         r_buttons   <= '0;
         r_scan_done <= 1'b0;
         r_changed   <= 1'b0;
         r_col_n     <= 4'b1111;
      end else begin
         r_state     <= w_state_nxt;
         r_col       <= w_col_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rs1       <= bus.row_n;
         r_rs2       <= r_rs1;
         r_shadow    <= w_shadow_nxt;
         r_buttons   <= w_buttons_nxt;
         r_scan_done <= w_scan_done_nxt;
         r_changed   <= w_changed_nxt;
         r_col_n     <= w_col_n_nxt;
      end
   end

   assign bus.col_n     = r_col_n;
   assign bus.buttons   = r_buttons;
   assign bus.scan_done = r_scan_done;
   assign bus.changed   = r_changed;

endmodule

// File: tb/tb_jag_controller_scanner.sv
// tb_jag_controller_scanner
// Directed bench for jag_controller_scanner with SETTLE = 4 and a combinational pad model
// that answers col_n with the row pattern of the currently pressed buttons.
module tb_jag_controller_scanner;
   localparam int unsigned S = 4;

   logic        clk;
   logic        reset_n;
   logic        en;
   logic [20:0] pressed;
   logic        glitch_en;
   logic [6:1]  glitch_val;
   logic [6:1]  row_drv;
   int          n_checks;
   int          n_fail;
   int          col_viol;

   jag_controller_scanner_if bus ();

   jag_controller_scanner #(
      .SETTLE (S)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.en    = en;
   assign bus.row_n = row_drv;

   // Pad model: selected column pulls the rows of its pressed buttons low.
   always_comb begin
      row_drv = 6'b111111;
      case (bus.col_n)
         4'b1110: row_drv[6:2] = ~{pressed[20], pressed[18], pressed[15], pressed[12], pressed[7]};
         4'b1101: row_drv[6:2] = ~{pressed[9], pressed[17], pressed[14], pressed[11], pressed[6]};
         4'b1011: row_drv[6:2] = ~{pressed[19], pressed[16], pressed[13], pressed[10], pressed[5]};
         4'b0111: row_drv = ~{pressed[3], pressed[2], pressed[1], pressed[0], pressed[4], pressed[8]};
         default: row_drv = 6'b111111;
      endcase
      if (glitch_en) row_drv = glitch_val;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ($countones(~bus.col_n) > 1) col_viol++;
   end

   // Returns edges elapsed until scan_done is seen high at a falling edge.
   task automatic wait_done(input int budget, output int n, output bit to);
      n  = 0;
      to = 1'b1;
      while (n < budget) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.scan_done === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_col(input logic [3:0] target, input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.col_n === target) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      bit to;
      reset_n = 1'b0;
      en      = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.col_n !== 4'b1111) begin
         n_fail++; $display("FAIL reset_col_n: got %b expected 1111", bus.col_n);
      end
      n_checks++;
      if (bus.buttons !== 21'h0) begin
         n_fail++; $display("FAIL reset_buttons: got %h expected 000000", bus.buttons);
      end
      n_checks++;
      if (bus.scan_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_scan_done: got %b expected 0", bus.scan_done);
      end
      n_checks++;
      if (bus.changed !== 1'b0) begin
         n_fail++; $display("FAIL reset_changed: got %b expected 0", bus.changed);
      end
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.col_n !== 4'b1110) begin
         n_fail++; $display("FAIL startup_col_n: got %b expected 1110", bus.col_n);
      end
      wait_done(200, n, to);
      n_checks++;
      if (to || n != 4 * S + 3) begin
         n_fail++;
         $display("FAIL first_done_latency: got %0d (timeout %0d) expected %0d", n, to, 4 * S + 3);
      end
   endtask

   task automatic test_full_map();
      int n;
      bit to;
      logic [20:0] exp;
      for (int i = 0; i <= 21; i++) begin
         exp     = (i == 21) ? 21'h1FFFFF : (21'd1 << i);
         pressed = exp;
         wait_done(100, n, to);
         wait_done(100, n, to);
         n_checks++;
         if (to || bus.buttons !== exp) begin
            n_fail++;
            $display("FAIL map_%0d: got %h expected %h (timeout %0d)", i, bus.buttons, exp, to);
         end
      end
   endtask

   task automatic test_change();
      int n;
      bit to;
      pressed = 21'h000010;
      wait_done(100, n, to);
      wait_done(100, n, to);
      n_checks++;
      if (to || bus.buttons !== 21'h000010) begin
         n_fail++; $display("FAIL change_base: got %h expected 000010", bus.buttons);
      end
      pressed = 21'h000018;
      wait_done(100, n, to);
      n_checks++;
      if (to || bus.changed !== 1'b1 || bus.buttons !== 21'h000018) begin
         n_fail++;
         $display("FAIL change_pulse: got changed=%b buttons=%h expected 1/000018",
                  bus.changed, bus.buttons);
      end
      @(negedge clk);
      n_checks++;
      if (bus.changed !== 1'b0 || bus.scan_done !== 1'b0) begin
         n_fail++;
         $display("FAIL change_width: got changed=%b done=%b expected 0/0",
                  bus.changed, bus.scan_done);
      end
      for (int k = 0; k < 2; k++) begin
         wait_done(100, n, to);
         n_checks++;
         if (to || bus.changed !== 1'b0 || bus.buttons !== 21'h000018) begin
            n_fail++;
            $display("FAIL change_steady_%0d: got changed=%b buttons=%h expected 0/000018",
                     k, bus.changed, bus.buttons);
         end
      end
   endtask

   task automatic test_enable();
      bit to;
      int pulses;
      wait_col(4'b1101, 100, to);
      n_checks++;
      if (to) begin
         n_fail++; $display("FAIL enable_find_drive2: got timeout expected col_n 1101");
      end
      en     = 1'b0;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.scan_done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++; $display("FAIL enable_done_count: got %0d expected 1", pulses);
      end
      n_checks++;
      if (bus.col_n !== 4'b1111 || bus.buttons !== 21'h000018) begin
         n_fail++;
         $display("FAIL enable_idle: got col_n=%b buttons=%h expected 1111/000018",
                  bus.col_n, bus.buttons);
      end
      pressed = 21'h100000;
      repeat (30) @(negedge clk);
      n_checks++;
      if (bus.col_n !== 4'b1111 || bus.buttons !== 21'h000018 || bus.scan_done !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_hold: got col_n=%b buttons=%h done=%b expected 1111/000018/0",
                  bus.col_n, bus.buttons, bus.scan_done);
      end
   endtask

   task automatic test_glitch();
      int n;
      bit to;
      pressed = 21'h000020;
      en      = 1'b1;
      wait_col(4'b1011, 100, to);
      n_checks++;
      if (to) begin
         n_fail++; $display("FAIL glitch_find_drive3: got timeout expected col_n 1011");
      end
      glitch_val = 6'b000000;
      glitch_en  = 1'b1;
      @(negedge clk);
      glitch_en  = 1'b0;
      wait_done(100, n, to);
      n_checks++;
      if (to || bus.buttons !== 21'h000020 || bus.changed !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_result: got buttons=%h changed=%b expected 000020/1",
                  bus.buttons, bus.changed);
      end
      n_checks++;
      if (col_viol != 0) begin
         n_fail++; $display("FAIL col_one_hot: got %0d violations expected 0", col_viol);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit to;
      pressed = 21'h000010;
      wait_done(100, n, to);
      wait_done(100, n, to);
      n_checks++;
      if (to || bus.buttons !== 21'h000010) begin
         n_fail++; $display("FAIL rmid_base: got %h expected 000010", bus.buttons);
      end
      wait_col(4'b1011, 100, to);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.buttons !== 21'h0 || bus.col_n !== 4'b1111 || bus.scan_done !== 1'b0 ||
          bus.changed !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_async: got buttons=%h col_n=%b done=%b changed=%b expected 0/1111/0/0",
                  bus.buttons, bus.col_n, bus.scan_done, bus.changed);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.col_n !== 4'b1110 || bus.scan_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_restart: got col_n=%b done=%b expected 1110/0",
                  bus.col_n, bus.scan_done);
      end
      wait_done(200, n, to);
      n_checks++;
      if (to || n != 4 * S + 3 || bus.buttons !== 21'h000010) begin
         n_fail++;
         $display("FAIL rmid_rescan: got n=%0d buttons=%h expected %0d/000010",
                  n, bus.buttons, 4 * S + 3);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      col_viol   = 0;
      reset_n    = 1'b0;
      en         = 1'b0;
      pressed    = '0;
      glitch_en  = 1'b0;
      glitch_val = 6'b111111;
      @(negedge clk);
      test_reset();
      test_full_map();
      test_change();
      test_enable();
      test_glitch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
